// File: rtl/ntt_pkg.sv
// ntt_pkg: shared scheduler state type and width helpers
package ntt_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} sched_state_t;

    localparam int DRAIN_W = 4;

    function automatic int stage_w(input int logp);
        return $clog2(logp + 1);
    endfunction

endpackage

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: maps (stage, j, inv) to butterfly operand and twiddle addresses
module ntt_addr_gen import ntt_pkg::*; #(
    parameter int LOGP = 8
) (
    input  logic [stage_w(LOGP)-1:0] stage,
    input  logic [LOGP-2:0]          j,
    input  logic                     inv,
    output logic [LOGP-1:0]          addr_a,
    output logic [LOGP-1:0]          addr_b,
    output logic [LOGP-1:0]          tf_addr
);

    localparam int SW = stage_w(LOGP);

    logic [SW-1:0]   lh;
    logic [LOGP-1:0] jx, h, g, k;

    // lh = log2(half-span): NTT shrinks the span each stage, INTT grows it
    always_comb begin
        lh      = inv ? stage : SW'(LOGP - 1) - stage;
        jx      = {1'b0, j};
        h       = LOGP'(1) << lh;
        g       = jx >> lh;
        k       = jx & (h - 1'b1);
        addr_a  = (g << (lh + 1'b1)) | k;
        addr_b  = addr_a + h;
        tf_addr = (LOGP'(1) << (SW'(LOGP - 1) - lh)) + g;
    end

endmodule

// File: rtl/ntt_butterfly_scheduler.sv
// ntt_butterfly_scheduler: issues the butterfly beats of one in-place NTT/INTT with drain gaps between stages
module ntt_butterfly_scheduler import ntt_pkg::*; #(
    parameter int LOGP     = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     inv,
    input  logic                     bf_ready,
    output logic                     bf_valid,
    output logic [LOGP-1:0]          addr_a,
    output logic [LOGP-1:0]          addr_b,
    output logic [LOGP-1:0]          tf_addr,
    output logic                     pe_inv,
    output logic [stage_w(LOGP)-1:0] stage,
    output logic                     busy,
    output logic                     done
);

    localparam int                SW         = stage_w(LOGP);
    localparam logic [SW-1:0]      LAST_STAGE = SW'(LOGP - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(PIPE_LAT - 1);

    sched_state_t        state, state_nxt;
    logic [LOGP-2:0]     j;
    logic [DRAIN_W-1:0]  dcnt;
    logic                inv_q;
    logic                accept, last_beat, drain_end;
    logic [LOGP-1:0]     a_raw, b_raw, t_raw;

    ntt_addr_gen #(.LOGP(LOGP)) u_addr_gen (
        .stage   (stage),
        .j       (j),
        .inv     (inv_q),
        .addr_a  (a_raw),
        .addr_b  (b_raw),
        .tf_addr (t_raw)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // beat counter, drain counter, stage index and latched direction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            j     <= '0;
            dcnt  <= '0;
            stage <= '0;
            inv_q <= 1'b0;
        end else if (state == IDLE && start) begin
            j     <= '0;
            dcnt  <= '0;
            stage <= '0;
            inv_q <= inv;
        end else if (state == ISSUE && accept) begin
            j <= j + 1'b1;
        end else if (state == DRAIN) begin
            dcnt <= drain_end ? '0 : dcnt + 1'b1;
            if (drain_end) stage <= (stage == LAST_STAGE) ? '0 : stage + 1'b1;
        end
    end

    // next state and outputs; beat fields are zeroed whenever no beat is offered
    always_comb begin
        state_nxt = state;
        bf_valid  = (state == ISSUE);
        accept    = bf_valid && bf_ready;
        last_beat = (j == '1);
        drain_end = (dcnt == LAST_DRAIN);
        busy      = (state == ISSUE) || (state == DRAIN);
        done      = (state == DONE);
        pe_inv    = inv_q;
        addr_a    = bf_valid ? a_raw : '0;
        addr_b    = bf_valid ? b_raw : '0;
        tf_addr   = bf_valid ? t_raw : '0;
        if (state == IDLE && start)                    state_nxt = ISSUE;
        else if (state == ISSUE && accept && last_beat) state_nxt = DRAIN;
        else if (state == DRAIN && drain_end)           state_nxt = (stage == LAST_STAGE) ? DONE : ISSUE;
        else if (state == DONE)                         state_nxt = IDLE;
    end

endmodule
